icache_invalidation_unit: RTL and testbench

ICACHE_INVALIDATION_UNIT -- requirements
Module: icache_invalidation_unit

---
 rtl/icache_invalidation_unit_pkg.sv | 31 +++
 rtl/icache_invalidation_unit_if.sv | 38 +++
 rtl/icache_invalidation_unit_inv_tag_match.sv | 20 ++
 rtl/icache_invalidation_unit.sv | 193 +++++++++++++++++++
 tb/tb_icache_invalidation_unit.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_invalidation_unit_pkg.sv
// Shared types and address-split helpers for the I-cache invalidation unit.
// Invalidation addresses are 30-bit word addresses laid out as {tag, index, offset}.
package icache_invalidation_unit_pkg;

  localparam int ADDR_W = 30;

  // Controller states: single-line invalidation (RD -> CMP -> WR) or full-cache walk (FLUSH).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CMP   = 3'd2,
    ST_WR    = 3'd3,
    ST_FLUSH = 3'd4
  } inv_state_e;

  // Tag width left over once index and word-offset bits are removed from the address.
  function automatic int tag_width(input int index_w, input int offset_w);
    return ADDR_W - index_w - offset_w;
  endfunction

  // Bit position of the least-significant index bit.
  function automatic int index_lsb(input int offset_w);
    return offset_w;
  endfunction

  // Bit position of the least-significant tag bit.
  function automatic int tag_lsb(input int index_w, input int offset_w);
    return index_w + offset_w;
  endfunction

endpackage

// File: rtl/icache_invalidation_unit_if.sv
// Tag-array access port shared between the invalidation unit (master) and the
// arbitrated tag RAM (slave). An access takes place on a cycle with
// tag_req & tag_gnt; read data returns exactly one cycle after a granted read.
interface icache_invalidation_unit_if #(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 21
);

  logic                  tag_req;
  logic                  tag_we;
  logic [INDEX_W-1:0]    tag_index;
  logic [WAYS-1:0]       tag_way_mask;
  logic                  tag_gnt;
  logic [WAYS-1:0]       tag_rd_valid;
  logic [WAYS*TAG_W-1:0] tag_rd_tag;

  modport master (
    output tag_req,
    output tag_we,
    output tag_index,
    output tag_way_mask,
    input  tag_gnt,
    input  tag_rd_valid,
    input  tag_rd_tag
  );

  modport slave (
    input  tag_req,
    input  tag_we,
    input  tag_index,
    input  tag_way_mask,
    output tag_gnt,
    output tag_rd_valid,
    output tag_rd_tag
  );

endinterface

// File: rtl/icache_invalidation_unit_inv_tag_match.sv
// Parallel tag comparator: one bit per way, set when that way holds a valid
// line whose stored tag equals the tag being invalidated.
module inv_tag_match #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 21
) (
  input  logic [WAYS-1:0]       rd_valid,
  input  logic [WAYS*TAG_W-1:0] rd_tag,
  input  logic [TAG_W-1:0]      cmp_tag,
  output logic [WAYS-1:0]       match
);

  // Compare every way in the same cycle; ways are packed way0 in the low bits.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      match[w] = rd_valid[w] && (rd_tag[w*TAG_W +: TAG_W] == cmp_tag);
    end
  end

endmodule

// File: rtl/icache_invalidation_unit.sv
// I-cache invalidation unit. Pops single-line invalidations from an upstream
// queue (read tags, compare, clear the matching ways) and performs full-cache
// flushes for fence.i by walking every set and clearing all ways. The set
// currently being invalidated is locked against refills.
module icache_invalidation_unit
  import icache_invalidation_unit_pkg::*;
#(
  parameter int  WAYS     = 2,
  parameter int  INDEX_W  = 6,
  parameter int  OFFSET_W = 3,
  localparam int TAG_W    = tag_width(INDEX_W, OFFSET_W)
) (
  input  logic                        clk,
  input  logic                        rst_n,

  // Queued invalidation request
  input  logic                        inv_valid,
  input  logic [ADDR_W-1:0]           inv_addr,
  output logic                        inv_completed,

  // Full-cache flush
  input  logic                        flush_req,
  output logic                        flush_ack,

  // Tag-array port
  icache_invalidation_unit_if.master  tag_port,

  // Fill lock and status
  output logic                        lock_valid,
  output logic [INDEX_W-1:0]          lock_index,
  output logic                        busy
);

  localparam int IDX_LSB = index_lsb(OFFSET_W);
  localparam int TAG_LSB = tag_lsb(INDEX_W, OFFSET_W);

  inv_state_e         state_q, state_d;
  logic [TAG_W-1:0]   cap_tag_q;
  logic [INDEX_W-1:0] cap_index_q;
  logic [WAYS-1:0]    match_q;
  logic [INDEX_W-1:0] flush_cnt_q;

  logic               capture;
  logic               flush_last;
  logic [WAYS-1:0]    match_w;

  logic               tag_req;
  logic               tag_we;
  logic [INDEX_W-1:0] tag_index;
  logic [WAYS-1:0]    tag_way_mask;

  // Word-offset bits select a word within the line and play no part in invalidation.
  logic unused_offset;
  assign unused_offset = ^inv_addr[OFFSET_W-1:0];

  inv_tag_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W)
  ) u_match (
    .rd_valid (tag_port.tag_rd_valid),
    .rd_tag   (tag_port.tag_rd_tag),
    .cmp_tag  (cap_tag_q),
    .match    (match_w)
  );

  assign flush_last = (flush_cnt_q == {INDEX_W{1'b1}});

  // Next-state and output decode.
  // NOTE: every output of this block is given a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    inv_completed = 1'b0;
    flush_ack     = 1'b0;
    tag_req       = 1'b0;
    tag_we        = 1'b0;
    tag_index     = '0;
    tag_way_mask  = '0;
    lock_valid    = 1'b0;
    lock_index    = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A flush outranks a queued invalidation; the queue entry waits.
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (inv_valid) begin
          capture = 1'b1;
          state_d = ST_RD;
        end
      end

      ST_RD: begin
        tag_req    = 1'b1;
        tag_index  = cap_index_q;
        lock_valid = 1'b1;
        lock_index = cap_index_q;
        if (tag_port.tag_gnt) begin
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        // Read data is valid this cycle; nothing matching means nothing to clear.
        lock_valid = 1'b1;
        lock_index = cap_index_q;
        if (|match_w) begin
          state_d = ST_WR;
        end else begin
          inv_completed = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_WR: begin
        tag_req      = 1'b1;
        tag_we       = 1'b1;
        tag_index    = cap_index_q;
        tag_way_mask = match_q;
        lock_valid   = 1'b1;
        lock_index   = cap_index_q;
        if (tag_port.tag_gnt) begin
          inv_completed = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        tag_req      = 1'b1;
        tag_we       = 1'b1;
        tag_index    = flush_cnt_q;
        tag_way_mask = {WAYS{1'b1}};
        if (tag_port.tag_gnt && flush_last) begin
          flush_ack = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  assign tag_port.tag_req      = tag_req;
  assign tag_port.tag_we       = tag_we;
  assign tag_port.tag_index    = tag_index;
  assign tag_port.tag_way_mask = tag_way_mask;

  // State register; reset drops any in-flight invalidation without completing it.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the tag and index of the accepted queue entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_tag_q   <= '0;
      cap_index_q <= '0;
    end else if (capture) begin
      cap_tag_q   <= inv_addr[TAG_LSB +: TAG_W];
      cap_index_q <= inv_addr[IDX_LSB +: INDEX_W];
    end
  end

  // Hold the compare result so the write can wait on arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= '0;
    end else if (state_q == ST_CMP) begin
      match_q <= match_w;
    end
  end

  // Flush walk counter: advances per granted write, returns to 0 after the last set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
    end else if (state_q == ST_FLUSH && tag_port.tag_gnt) begin
      if (flush_last) begin
        flush_cnt_q <= '0;
      end else begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_invalidation_unit.sv
// Self-checking bench for icache_invalidation_unit. The bench plays the tag RAM
// (a set/way array of valid bits and tags) and checks every transaction
// against outcomes derived from that array's contents.
module tb_icache_invalidation_unit;

  localparam int WAYS     = 2;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 3;
  localparam int TAG_W    = 30 - INDEX_W - OFFSET_W;
  localparam int SETS     = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               inv_valid;
  logic [29:0]        inv_addr;
  logic               inv_completed;
  logic               flush_req;
  logic               flush_ack;
  logic               lock_valid;
  logic [INDEX_W-1:0] lock_index;
  logic               busy;

  icache_invalidation_unit_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) tag_if ();

  icache_invalidation_unit #(
    .WAYS     (WAYS),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inv_valid     (inv_valid),
    .inv_addr      (inv_addr),
    .inv_completed (inv_completed),
    .flush_req     (flush_req),
    .flush_ack     (flush_ack),
    .tag_port      (tag_if),
    .lock_valid    (lock_valid),
    .lock_index    (lock_index),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Tag RAM contents as seen by the bench.
  bit               mem_vld [SETS][WAYS];
  logic [TAG_W-1:0] mem_tag [SETS][WAYS];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_lat;
  int done_cyc[$];
  logic [29:0] req_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int idx, input int way, input bit vld, input logic [TAG_W-1:0] tg);
    mem_vld[idx][way] = vld;
    mem_tag[idx][way] = tg;
  endtask

  // Ways an invalidation of this address must clear: valid lines with an equal tag.
  function automatic logic [WAYS-1:0] expected_mask(input logic [29:0] a);
    logic [WAYS-1:0] m;
    int idx;
    m   = '0;
    idx = int'(a[OFFSET_W +: INDEX_W]);
    for (int w = 0; w < WAYS; w++)
      if (mem_vld[idx][w] && mem_tag[idx][w] == a[29 -: TAG_W]) m[w] = 1'b1;
    return m;
  endfunction

  // Advance one clock: apply whatever tag access the DUT presented at the edge,
  // then drive read data (or garbage) for the new cycle.
  task automatic tick();
    bit rd, wr;
    logic [INDEX_W-1:0] idx;
    logic [WAYS-1:0] m;
    rd  = tag_if.tag_req && tag_if.tag_gnt && !tag_if.tag_we;
    wr  = tag_if.tag_req && tag_if.tag_gnt &&  tag_if.tag_we;
    idx = tag_if.tag_index;
    m   = tag_if.tag_way_mask;
    @(posedge clk);
    #1;
    cyc++;
    if (wr)
      for (int w = 0; w < WAYS; w++)
        if (m[w]) mem_vld[idx][w] = 1'b0;
    if (rd) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_if.tag_rd_valid[w] = mem_vld[idx][w];
        tag_if.tag_rd_tag[w*TAG_W +: TAG_W] = mem_tag[idx][w];
      end
    end else begin
      tag_if.tag_rd_valid = WAYS'($urandom());
      tag_if.tag_rd_tag   = (WAYS*TAG_W)'({$urandom(), $urandom()});
    end
  endtask

  // Feed every entry of req_q through the queue interface, back to back.
  task automatic run_queue(input int stall_rd, input bit rnd_gnt, input bit flush_mid);
    done_cyc.delete();
    for (int i = 0; i < req_q.size(); i++) begin
      logic [29:0] a;
      logic [WAYS-1:0] em;
      logic [INDEX_W-1:0] idx;
      int reads, writes, stalls;
      bit done;
      a      = req_q[i];
      em     = expected_mask(a);
      idx    = a[OFFSET_W +: INDEX_W];
      reads  = 0;
      writes = 0;
      stalls = 0;
      done   = 1'b0;
      inv_valid = 1'b1;
      inv_addr  = a;
      for (int k = 0; k < 200 && !done; k++) begin
        tag_if.tag_gnt = rnd_gnt ? ($urandom_range(0, 3) != 0) : !(k >= 1 && k <= stall_rd);
        if (flush_mid && k == 1) flush_req = 1'b1;
        #1;
        if (k == 0) begin
          check("accept_idle_busy", busy, 0);
          check("idle_tag_req", tag_if.tag_req, 0);
        end else begin
          check("lock_valid", lock_valid, 1);
          check("lock_index", lock_index, idx);
        end
        check("no_flush_ack_inv", flush_ack, 0);
        if (tag_if.tag_req && !tag_if.tag_gnt) stalls++;
        if (tag_if.tag_req && tag_if.tag_gnt) begin
          check("access_index", tag_if.tag_index, idx);
          if (tag_if.tag_we) begin
            writes++;
            check("write_mask", tag_if.tag_way_mask, em);
          end else begin
            reads++;
          end
        end
        if (inv_completed) begin
          done     = 1'b1;
          last_lat = k;
          check("latency", k, ((em != 0) ? 3 : 2) + stalls);
          check("read_count", reads, 1);
          check("write_count", writes, (em != 0) ? 1 : 0);
          done_cyc.push_back(cyc);
          if (i == req_q.size() - 1) inv_valid = 1'b0;
        end
        tick();
      end
      check("inv_completed_seen", done, 1);
    end
  endtask

  // Flush walk; caller raises flush_req while the DUT is idle in the current cycle.
  task automatic do_flush();
    int writes;
    bit done;
    writes = 0;
    done   = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tag_if.tag_gnt = 1'b1;
      #1;
      if (k == 0) check("flush_start_idle", busy, 0);
      check("no_inv_completed_flush", inv_completed, 0);
      if (tag_if.tag_req && tag_if.tag_gnt) begin
        check("flush_we", tag_if.tag_we, 1);
        check("flush_mask", tag_if.tag_way_mask, 2'b11);
        check("flush_index", tag_if.tag_index, writes);
        writes++;
      end
      if (flush_ack) begin
        done      = 1'b1;
        flush_req = 1'b0;
        check("flush_ack_cycle", k, 64);
        check("flush_write_count", writes, 64);
      end
      tick();
    end
    check("flush_ack_seen", done, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    inv_valid  = 1'b0;
    inv_addr   = '0;
    flush_req  = 1'b0;
    tag_if.tag_gnt      = 1'b0;
    tag_if.tag_rd_valid = '0;
    tag_if.tag_rd_tag   = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) set_line(s, w, 1'b0, '0);

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_tag_req", tag_if.tag_req, 0);
    check("rst_lock_valid", lock_valid, 0);
    check("rst_inv_completed", inv_completed, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Hit in way1 at index 0x06
    set_line(6, 0, 1'b1, 21'h5);
    set_line(6, 1, 1'b1, 21'h9);
    req_q = '{30'h0001234};
    run_queue(0, 1'b0, 1'b0);
    check("hit_latency_3", last_lat, 3);
    check("hit_cleared_way1", mem_vld[6][1], 0);
    check("hit_kept_way0", mem_vld[6][0], 1);

    // Same address again: now a miss
    run_queue(0, 1'b0, 1'b0);
    check("miss_latency_2", last_lat, 2);

    // Grant withheld for 5 cycles in RD
    set_line(6, 1, 1'b1, 21'h9);
    run_queue(5, 1'b0, 1'b0);
    check("stall_latency_8", last_lat, 8);

    // Four back-to-back hits
    for (int i = 0; i < 4; i++) set_line(10 + i, i % 2, 1'b1, 21'(100 + i));
    req_q = '{{21'd100, 6'd10, 3'd1}, {21'd101, 6'd11, 3'd2},
              {21'd102, 6'd12, 3'd3}, {21'd103, 6'd13, 3'd4}};
    run_queue(0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) check("b2b_spacing", done_cyc[i] - done_cyc[i-1], 4);

    // Flush requested mid-invalidation waits for completion
    set_line(20, 0, 1'b1, 21'h77);
    req_q = '{{21'h77, 6'd20, 3'd0}};
    run_queue(0, 1'b0, 1'b1);
    check("flush_pending_after_inv", flush_req, 1);
    do_flush();

    // Flush and invalidation both pending: flush first, then the entry (now a miss)
    set_line(6, 1, 1'b1, 21'h9);
    inv_valid = 1'b1;
    inv_addr  = 30'h0001234;
    flush_req = 1'b1;
    do_flush();
    check("flush_cleared_line", mem_vld[6][1], 0);
    req_q = '{30'h0001234};
    run_queue(0, 1'b0, 1'b0);
    check("post_flush_miss_latency", last_lat, 2);

    // Reset asserted during WR
    set_line(6, 1, 1'b1, 21'h9);
    inv_valid = 1'b1;
    inv_addr  = 30'h0001234;
    for (int k = 0; k < 3; k++) begin
      tag_if.tag_gnt = (k <= 1);
      #1;
      tick();
    end
    tag_if.tag_gnt = 1'b0;
    #1;
    check("in_wr_we", tag_if.tag_we, 1);
    check("in_wr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_inv_completed", inv_completed, 0);
    check("async_rst_flush_ack", flush_ack, 0);
    check("async_rst_tag_req", tag_if.tag_req, 0);
    check("async_rst_tag_we", tag_if.tag_we, 0);
    check("async_rst_mask", tag_if.tag_way_mask, 0);
    check("async_rst_lock", lock_valid, 0);
    check("async_rst_busy", busy, 0);
    inv_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_no_complete", inv_completed, 0);
    check("aborted_line_untouched", mem_vld[6][1], 1);
    tick();

    // Randomized invalidations with random grant
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) set_line(s, w, $urandom_range(0, 1), TAG_W'($urandom_range(0, 7)));
    req_q.delete();
    for (int i = 0; i < 40; i++)
      req_q.push_back({TAG_W'($urandom_range(0, 7)), INDEX_W'($urandom()), OFFSET_W'($urandom())});
    run_queue(0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
